uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive engine driven by the 8x oversample strobe from the baud-rate block. Recovers 1 start bit, 8 data bits (LSB first), an optional parity bit and 1 stop bit from the serial line. Presents each byte to the host with a valid/ack handshake and per-frame error flags. Runs entirely in the clk_in domain; the strobe is a clock enable, not a clock.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 8, rx_tick pulses per bit period; must be even and >= 4.

Ports:
clk_in  input  1  system clock; the only clock.
rst  input  1  asynchronous reset, active-high.
rx_tick  input  1  one-clk_in-cycle strobe at OVERSAMPLE x baud rate.
rx_in  input  1  serial line, idle high, asynchronous to clk_in.
parity_en  input  1  1 = frame carries a parity bit.
parity_odd  input  1  1 = odd parity, 0 = even parity.
rx_ack  input  1  host consumes rx_data; clears rx_valid.
rx_data  output  DATA_BITS  last received byte.
rx_valid  output  1  byte available; held until acknowledged.
frame_err  output  1  stop bit of the last frame sampled 0.
parity_err  output  1  parity mismatch in the last frame.
overrun  output  1  a frame completed while rx_valid=1 and rx_ack=0.
busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all outputs 0, rx_data=0, both synchroniser flops=1, counters=0. Asserting reset mid-frame abandons the frame with no output update.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s and occur only in cycles where rx_tick=1. Counters and state advance only on ticks.
- Tick counter tcnt, 0..OVERSAMPLE-1. Bit counter bcnt, 0..DATA_BITS-1.
- IDLE: on a tick with rx_s=0 -> START, tcnt=0. Latch parity_en and parity_odd here; mid-frame changes are ignored.
- START: tcnt increments each tick. When tcnt reaches OVERSAMPLE/2-1 (mid-bit), sample rx_s:
  - rx_s=0 -> DATA, tcnt=0, bcnt=0.
  - rx_s=1 -> false start; return to IDLE with no output.
- DATA: on the tick where tcnt=OVERSAMPLE-1, sample rx_s into the shift register (LSB first), set tcnt=0 and increment bcnt. After bit DATA_BITS-1 -> PARITY if latched parity_en, else STOP.
- PARITY: sample at tcnt=OVERSAMPLE-1. Error if (XOR of data bits XOR sampled bit) != latched parity_odd. Then -> STOP.
- STOP: sample at tcnt=OVERSAMPLE-1. This is the completion cycle. On the following clk_in edge:
  - rx_data <= shift register.
  - rx_valid <= 1.
  - frame_err <= (stop sample==0).
  - parity_err <= computed error (0 if parity disabled).
  - overrun <= rx_valid & ~rx_ack.
  - Next state: IDLE if stop=1, else BREAK. Back-to-back frames start from mid-stop-bit.
- BREAK: stay until a tick samples rx_s=1, then -> IDLE. A held-low line therefore yields exactly one framing-error frame.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid and overrun on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - Completion in the same cycle as rx_ack: the new frame wins. rx_valid stays 1, overrun=0, data and flags are replaced.
- Overrun: the newest byte always overwrites rx_data. overrun stays sticky until rx_ack.
- frame_err and parity_err hold until the next completion.
- Errored frames still assert rx_valid.
- Latency: rx_valid rises 1 clk_in after the stop-bit sampling tick.
- busy falls when the state returns to IDLE.

Test Plan:
- Bench drives rx_tick once every 4 clk_in (32 clk per bit); parity off; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> rx_valid=1 with rx_data=0xA5, frame_err=0, parity_err=0; rx_ack clears rx_valid next cycle.
- parity_en=1, parity_odd=0: send 0xA5 with parity bit 0 -> parity_err=0. Send 0xA5 with parity bit 1 -> parity_err=1, rx_data=0xA5, rx_valid=1. Repeat with parity_odd=1 and bit 1 -> parity_err=0.
- Glitch: rx_in low for 2 ticks, then high -> no rx_valid, busy returns to 0, next valid frame 0x3C is received correctly.
- Send 0x00 followed by a low stop bit, line held low 20 bit times -> single completion with rx_data=0x00, frame_err=1. FSM stays in BREAK until the line goes high; next frame 0x81 is received with frame_err=0.
- Send 0x11 then 0x22 back-to-back without rx_ack -> second completion gives rx_data=0x22, overrun=1. rx_ack clears both rx_valid and overrun. Separately, ack coincident with completion -> rx_valid=1, overrun=0.
- Assert rst for 1 cycle during data bit 4 of 0x55 -> all outputs 0 and busy=0. The following clean frame 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 or 8-with-parity frames sampled on an oversample clock enable.
// Single clk_in domain; bytes are held for the host under a valid/ack handshake with sticky overrun.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 rx_tick,
   input  logic                 rx_in,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t                state_q, state_d;
   logic                  sync_q, rx_s_q;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  pen_q, pen_d, podd_q, podd_d, perr_q, perr_d;
   logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  parity_err_q, parity_err_d;
   logic                  overrun_q, overrun_d;
   logic                  done;

   always_comb begin
      state_d      = state_q;
      tcnt_d       = tcnt_q;
      bcnt_d       = bcnt_q;
      shift_d      = shift_q;
      pen_d        = pen_q;
      podd_d       = podd_q;
      perr_d       = perr_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;
      done         = 1'b0;

      if (rx_tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d = S_START;
                  tcnt_d  = '0;
                  pen_d   = parity_en;
                  podd_d  = parity_odd;
                  perr_d  = 1'b0;
               end
            end
            S_START: begin
               if (tcnt_q == T_MID) begin
                  tcnt_d = '0;
                  bcnt_d = '0;
                  state_d = rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_DATA: begin
               if (tcnt_q == T_END) begin
                  // LSB arrives first, so shift in from the top
                  shift_d = DATA_BITS'({rx_s_q, shift_q} >> 1);
                  tcnt_d  = '0;
                  bcnt_d  = bcnt_q + BW'(1);
                  if (bcnt_q == B_LAST) begin
                     bcnt_d  = '0;
                     state_d = pen_q ? S_PARITY : S_STOP;
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_PARITY: begin
               if (tcnt_q == T_END) begin
                  perr_d  = ((^shift_q) ^ rx_s_q) != podd_q;
                  tcnt_d  = '0;
                  state_d = S_STOP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_STOP: begin
               if (tcnt_q == T_END) begin
                  done    = 1'b1;
                  tcnt_d  = '0;
                  state_d = rx_s_q ? S_IDLE : S_BREAK;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_BREAK: begin
               if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A completing frame takes priority over a coincident acknowledge
      if (done) begin
         rx_data_d    = shift_q;
         rx_valid_d   = 1'b1;
         frame_err_d  = ~rx_s_q;
         parity_err_d = perr_q;
         overrun_d    = rx_valid_q & ~rx_ack;
      end else if (rx_valid_q && rx_ack) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_q       <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= S_IDLE;
         tcnt_q       <= '0;
         bcnt_q       <= '0;
         shift_q      <= '0;
         pen_q        <= 1'b0;
         podd_q       <= 1'b0;
         perr_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync_q       <= rx_in;
         rx_s_q       <= sync_q;
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         bcnt_q       <= bcnt_d;
         shift_q      <= shift_d;
         pen_q        <= pen_d;
         podd_q       <= podd_d;
         perr_q       <= perr_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed serial frames into uart_rx; a scoreboard queue holds the expected byte and flags,
// and an independent monitor compares each completion the receiver presents.
module tb_uart_rx;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       ov;
   } exp_t;

   logic       clk_in, rst, rx_tick, rx_in, parity_en, parity_odd, rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun, busy;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   done_cyc = 0;
   int   lat = 0;
   exp_t exp_q[$];

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8)) dut (
      .clk_in(clk_in), .rst(rst), .rx_tick(rx_tick), .rx_in(rx_in),
      .parity_en(parity_en), .parity_odd(parity_odd), .rx_ack(rx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun), .busy(busy)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cyc <= cyc + 1;

   // one rx_tick every 4 clocks -> 32 clocks per bit
   initial begin
      int tk;
      tk = 0;
      rx_tick = 1'b0;
      forever begin
         @(posedge clk_in);
         #1;
         rx_tick = (tk == 3);
         tk = (tk + 1) % 4;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
      exp_t e;
      e.d = d; e.fe = fe; e.pe = pe; e.ov = ov;
      return e;
   endfunction

   // Monitor: a completion is a rising rx_valid, or new content while rx_valid stays high
   initial begin
      logic       pv, pf, pp, po;
      logic [7:0] pd;
      exp_t       e;
      pv = 0; pf = 0; pp = 0; po = 0; pd = 0;
      forever begin
         @(negedge clk_in);
         if (!rst && rx_valid &&
             (!pv || rx_data != pd || frame_err != pf || parity_err != pp || overrun != po)) begin
            done_cyc = cyc;
            check("mon_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("mon_data", rx_data, e.d);
               check("mon_frame_err", frame_err, e.fe);
               check("mon_parity_err", parity_err, e.pe);
               check("mon_overrun", overrun, e.ov);
            end
         end
         pv = rx_valid; pd = rx_data; pf = frame_err; pp = parity_err; po = overrun;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      wait_cycles(32);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      wait_cycles(n);
   endtask

   // start each frame at the same phase relative to rx_tick so latency is repeatable
   task automatic align_tick();
      int n;
      n = 0;
      @(negedge clk_in);
      while (!rx_tick && n < 8) begin
         @(negedge clk_in);
         n++;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stopb, input logic align);
      if (align) align_tick();
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pen) drive_bit(pbit);
      drive_bit(stopb);
   endtask

   task automatic ack_and_check(input string name);
      @(posedge clk_in);
      #1 rx_ack = 1'b1;
      @(posedge clk_in);
      #1 rx_ack = 1'b0;
      @(negedge clk_in);
      check({name, "_valid_clr"}, rx_valid, 0);
      check({name, "_ovr_clr"}, overrun, 0);
   endtask

   initial begin
      rst = 1'b1; rx_in = 1'b1; rx_ack = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
      wait_cycles(3);
      rst = 1'b0;
      @(negedge clk_in);
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      idle(40);

      // basic frame, no parity; also calibrates completion latency
      exp_q.push_back(mk(8'hA5, 0, 0, 0));
      send_frame(8'hA5, 0, 0, 1, 1);
      lat = done_cyc - start_cyc;
      check("latency_in_stop_bit", (lat >= 288 && lat < 320), 1);
      idle(16);
      ack_and_check("a5");

      // parity: even/good, even/bad, odd/good
      parity_en = 1'b1; parity_odd = 1'b0;
      exp_q.push_back(mk(8'hA5, 0, 0, 0));
      send_frame(8'hA5, 1, 0, 1, 1);
      idle(16);
      ack_and_check("par_even_ok");
      exp_q.push_back(mk(8'hA5, 0, 1, 0));
      send_frame(8'hA5, 1, 1, 1, 1);
      idle(16);
      ack_and_check("par_even_bad");
      parity_odd = 1'b1;
      exp_q.push_back(mk(8'hA5, 0, 0, 0));
      send_frame(8'hA5, 1, 1, 1, 1);
      idle(16);
      ack_and_check("par_odd_ok");
      parity_en = 1'b0; parity_odd = 1'b0;

      // glitch: low for two ticks only
      align_tick();
      rx_in = 1'b0;
      wait_cycles(8);
      rx_in = 1'b1;
      check("glitch_busy_rise", busy, 1);
      wait_cycles(64);
      check("glitch_busy_fall", busy, 0);
      exp_q.push_back(mk(8'h3C, 0, 0, 0));
      send_frame(8'h3C, 0, 0, 1, 1);
      idle(16);
      ack_and_check("x3c");

      // break: low stop bit then line held low
      exp_q.push_back(mk(8'h00, 1, 0, 0));
      send_frame(8'h00, 0, 0, 0, 1);
      wait_cycles(20 * 32);
      check("break_busy", busy, 1);
      idle(64);
      check("break_exit_busy", busy, 0);
      ack_and_check("brk");
      exp_q.push_back(mk(8'h81, 0, 0, 0));
      send_frame(8'h81, 0, 0, 1, 1);
      idle(16);
      ack_and_check("x81");

      // back-to-back without ack -> overrun
      exp_q.push_back(mk(8'h11, 0, 0, 0));
      exp_q.push_back(mk(8'h22, 0, 0, 1));
      send_frame(8'h11, 0, 0, 1, 1);
      send_frame(8'h22, 0, 0, 1, 0);
      idle(16);
      check("ovr_valid_held", rx_valid, 1);
      ack_and_check("ovr");

      // ack landing on the completion edge
      exp_q.push_back(mk(8'h33, 0, 0, 0));
      send_frame(8'h33, 0, 0, 1, 1);
      idle(16);
      exp_q.push_back(mk(8'h44, 0, 0, 0));
      fork
         send_frame(8'h44, 0, 0, 1, 1);
         begin : ack_at_done
            bit hit;
            hit = 0;
            for (int i = 0; i < 2000 && !hit; i++) begin
               @(posedge clk_in);
               #2;
               if (cyc == start_cyc + lat - 1) begin
                  rx_ack = 1'b1;
                  @(posedge clk_in);
                  #1 rx_ack = 1'b0;
                  hit = 1;
               end
            end
            check("coin_ack_issued", hit, 1);
         end
      join
      idle(16);
      check("coin_valid_kept", rx_valid, 1);
      check("coin_data", rx_data, 8'h44);

      // reset during data bit 4 of 0x55 (rx_valid is high going in)
      align_tick();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
      rx_in = 1'b1;
      wait_cycles(16);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      @(negedge clk_in);
      check("mrst_valid", rx_valid, 0);
      check("mrst_data", rx_data, 0);
      check("mrst_frame_err", frame_err, 0);
      check("mrst_parity_err", parity_err, 0);
      check("mrst_overrun", overrun, 0);
      check("mrst_busy", busy, 0);
      idle(200);
      check("mrst_idle_busy", busy, 0);
      exp_q.push_back(mk(8'hF0, 0, 0, 0));
      send_frame(8'hF0, 0, 0, 1, 1);
      idle(64);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
